// File: rtl/noc_inject_port_if.sv
// Producer-side handshake and NoC-side word/stall signals for one injection port.
// The slave view is the port itself; the master view is the producer plus NoC slot.
interface noc_inject_port_if #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned log_n_add = 6,
  parameter int unsigned ctrl_bit  = 1
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [bit_width-1:0]                  in_data;
  logic [log_n_add-1:0]                  in_addr;
  logic [bit_width+log_n_add+ctrl_bit-1:0] out_word;
  logic                                  stall;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_addr,
    input  stall,
    output in_ready,
    output out_word
  );

  modport master (
    output in_valid,
    output in_data,
    output in_addr,
    output stall,
    input  in_ready,
    input  out_word
  );
endinterface

// File: rtl/noc_inject_port.sv
// Per-multiplier NoC injection port: small FIFO plus an output register that holds the
// presented word stable under stall, with a bypass path when the FIFO is empty.
module noc_inject_port #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned log_n_add = 6,
  parameter int unsigned ctrl_bit  = 1,
  parameter int unsigned log_depth = 2
) (
  input  logic               clk,
  input  logic               rst,
  noc_inject_port_if.slave   bus,
  output logic [log_depth:0] occupancy,
  output logic [15:0]        stall_cycles
);

  localparam int unsigned depth = 1 << log_depth;
  localparam int unsigned ent_w = bit_width + log_n_add;
  localparam logic [log_depth:0] full_cnt = {1'b1, {log_depth{1'b0}}};

  typedef logic [ent_w-1:0] entry_t;

  entry_t               mem [depth];
  logic [log_depth-1:0] wr_ptr_q, wr_ptr_d;
  logic [log_depth-1:0] rd_ptr_q, rd_ptr_d;
  logic [log_depth:0]   count_q, count_d;
  logic                 or_valid_q, or_valid_d;
  entry_t               or_entry_q, or_entry_d;
  logic [15:0]          stall_cnt_q, stall_cnt_d;

  logic   ready;
  logic   accept;
  logic   consume;
  logic   or_free;
  logic   fifo_empty;
  logic   pop;
  logic   bypass;
  logic   push;
  entry_t in_entry;

  // Handshake decode; ready depends only on rst and registered state.
  always_comb begin
    ready      = !rst && (count_q < full_cnt);
    accept     = bus.in_valid & ready;
    in_entry   = {bus.in_addr, bus.in_data};
    consume    = or_valid_q & ~bus.stall;
    or_free    = ~or_valid_q | consume;
    fifo_empty = (count_q == '0);
    pop        = or_free & ~fifo_empty;
    bypass     = or_free & fifo_empty & accept;
    push       = accept & ~bypass;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // FIFO head has priority over the bypass path so ordering is preserved.
    or_valid_d = or_valid_q;
    or_entry_d = or_entry_q;
    if (or_free) begin
      if (pop) begin
        or_valid_d = 1'b1;
        or_entry_d = mem[rd_ptr_q];
      end else if (bypass) begin
        or_valid_d = 1'b1;
        or_entry_d = in_entry;
      end else begin
        or_valid_d = 1'b0;
        or_entry_d = '0;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (!or_valid_q || consume) begin
      stall_cnt_d = '0;
    end else if (stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      or_valid_q  <= 1'b0;
      or_entry_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      or_valid_q  <= or_valid_d;
      or_entry_q  <= or_entry_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_entry;
    end
  end

  always_comb begin
    bus.out_word                              = '0;
    bus.out_word[ent_w-1:0]                   = or_entry_q;
    bus.out_word[ent_w]                       = or_valid_q;
    bus.in_ready                              = ready;
    occupancy                                 = count_q;
    stall_cycles                              = stall_cnt_q;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && count_q == full_cnt))
    else $error("push into full FIFO");

  assert property (@(posedge clk) disable iff (rst) count_q <= full_cnt)
    else $error("occupancy above depth");

  assert property (@(posedge clk) disable iff (rst)
                   (or_valid_q && bus.stall) |=> $stable(bus.out_word))
    else $error("presented word changed under stall");

endmodule

// File: tb/tb_noc_inject_port.sv
// Randomized and directed bench for noc_inject_port against a word-queue reference model.
module tb_noc_inject_port;

  localparam int unsigned BW = 16;
  localparam int unsigned NA = 6;
  localparam int unsigned CB = 1;
  localparam int unsigned LD = 2;
  localparam int unsigned DEPTH = 1 << LD;

  logic        clk;
  logic        rst;
  logic [LD:0] occupancy;
  logic [15:0] stall_cycles;

  noc_inject_port_if #(.bit_width(BW), .log_n_add(NA), .ctrl_bit(CB)) bus ();

  noc_inject_port #(
    .bit_width(BW),
    .log_n_add(NA),
    .ctrl_bit (CB),
    .log_depth(LD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .occupancy   (occupancy),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: every word held by the port, oldest first; q[0] is the presented word.
  logic [BW+NA-1:0] q[$];
  logic [15:0]      m_sc = '0;
  logic [15:0]      got[$];

  function automatic logic [BW+NA+CB-1:0] exp_word();
    if (q.size() != 0) return {1'b1, q[0]};
    return '0;
  endfunction

  function automatic logic [LD:0] exp_occ();
    if (q.size() == 0) return '0;
    return (LD+1)'(q.size() - 1);
  endfunction

  function automatic logic exp_ready();
    return !rst && (q.size() <= DEPTH);
  endfunction

  // Advance one clock and update the model from the inputs that were present at the edge.
  task automatic tick();
    bit               busy;
    bit               acc;
    bit               stl;
    logic [BW+NA-1:0] w;
    busy = (q.size() != 0);
    acc  = bus.in_valid && exp_ready();
    stl  = bus.stall;
    w    = {bus.in_addr, bus.in_data};
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_sc = '0;
    end else begin
      if (busy && !stl) void'(q.pop_front());
      if (acc) q.push_back(w);
      if (busy && stl) m_sc = (m_sc == 16'hFFFF) ? m_sc : m_sc + 16'd1;
      else m_sc = '0;
    end
  endtask

  task automatic record_consume();
    if (bus.out_word[BW+NA] && !bus.stall) got.push_back(bus.out_word[BW-1:0]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hA5A5;
    bus.in_addr = 6'd3;
    bus.stall = 1'b0;
    tick();
    tick();
    n_chk++; if (bus.out_word !== '0) begin n_err++;
      $display("FAIL reset_word got=%h want=0", bus.out_word); end
    n_chk++; if (occupancy !== '0) begin n_err++;
      $display("FAIL reset_occ got=%0d want=0", occupancy); end
    n_chk++; if (stall_cycles !== '0) begin n_err++;
      $display("FAIL reset_sc got=%0d want=0", stall_cycles); end
    n_chk++; if (bus.in_ready !== 1'b0) begin n_err++;
      $display("FAIL reset_ready_low got=%b want=0", bus.in_ready); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_chk++; if (bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL reset_ready_release got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_single();
    logic [BW+NA+CB-1:0] want;
    want = {1'b1, 6'd5, 16'h1234};
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    bus.in_addr = 6'd5;
    bus.stall = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (bus.out_word !== want) begin n_err++;
      $display("FAIL single_word got=%h want=%h", bus.out_word, want); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL single_ready got=%b want=1", bus.in_ready); end
    tick();
    n_chk++; if (bus.out_word !== '0) begin n_err++;
      $display("FAIL single_gone got=%h want=0", bus.out_word); end
    n_chk++; if (bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL single_ready2 got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_stream();
    logic [BW+NA+CB-1:0] want;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'(i);
      bus.in_addr = 6'($urandom);
      bus.stall = 1'b0;
      want = {1'b1, bus.in_addr, bus.in_data};
      tick();
      n_chk++; if (bus.out_word !== want) begin n_err++;
        $display("FAIL stream_word[%0d] got=%h want=%h", i, bus.out_word, want); end
      n_chk++; if (occupancy !== '0) begin n_err++;
        $display("FAIL stream_occ[%0d] got=%0d want=0", i, occupancy); end
    end
    bus.in_valid = 1'b0;
    tick();
    n_chk++; if (bus.out_word !== '0) begin n_err++;
      $display("FAIL stream_end got=%h want=0", bus.out_word); end
  endtask

  task automatic test_backpressure();
    bit taken6;
    bit acc;
    got.delete();
    bus.stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h0100 + 16'(i);
      bus.in_addr = 6'(i);
      n_chk++; if (bus.in_ready !== (i < 5)) begin n_err++;
        $display("FAIL bp_ready[%0d] got=%b want=%b", i, bus.in_ready, (i < 5)); end
      tick();
    end
    n_chk++; if (occupancy !== 3'd4) begin n_err++;
      $display("FAIL bp_occ got=%0d want=4", occupancy); end
    n_chk++; if (bus.in_ready !== 1'b0) begin n_err++;
      $display("FAIL bp_ready_full got=%b want=0", bus.in_ready); end
    n_chk++; if (stall_cycles !== 16'd5) begin n_err++;
      $display("FAIL bp_sc got=%0d want=5", stall_cycles); end
    bus.stall = 1'b0;
    taken6 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      record_consume();
      acc = bus.in_valid && bus.in_ready;
      tick();
      if (acc) begin
        taken6 = 1'b1;
        bus.in_valid = 1'b0;
      end
      n_chk++; if (bus.out_word !== exp_word()) begin n_err++;
        $display("FAIL bp_drain[%0d] got=%h want=%h", i, bus.out_word, exp_word()); end
    end
    n_chk++; if (!taken6) begin n_err++;
      $display("FAIL bp_sixth_taken got=0 want=1"); end
    n_chk++; if (got.size() != 6) begin n_err++;
      $display("FAIL bp_count got=%0d want=6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      n_chk++; if (got[k] !== 16'h0100 + 16'(k)) begin n_err++;
        $display("FAIL bp_order[%0d] got=%h want=%h", k, got[k], 16'h0100 + 16'(k)); end
    end
  endtask

  task automatic test_full_pushpop();
    got.delete();
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h0200 + 16'(i);
      bus.in_addr = 6'(i + 8);
      tick();
    end
    bus.in_data = 16'h0205;
    bus.in_addr = 6'd7;
    n_chk++; if (occupancy !== 3'd4 || bus.in_ready !== 1'b0) begin n_err++;
      $display("FAIL pp_full got occ=%0d rdy=%b want occ=4 rdy=0", occupancy, bus.in_ready); end
    bus.stall = 1'b0;
    record_consume();
    tick();
    bus.stall = 1'b1;
    n_chk++; if (occupancy !== 3'd3 || bus.in_ready !== 1'b1) begin n_err++;
      $display("FAIL pp_one_out got occ=%0d rdy=%b want occ=3 rdy=1", occupancy, bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_chk++; if (occupancy !== 3'd4 || bus.in_ready !== 1'b0) begin n_err++;
      $display("FAIL pp_refill got occ=%0d rdy=%b want occ=4 rdy=0", occupancy, bus.in_ready); end
    n_chk++; if (bus.out_word !== {1'b1, 6'd9, 16'h0201}) begin n_err++;
      $display("FAIL pp_head got=%h want=%h", bus.out_word, {1'b1, 6'd9, 16'h0201}); end
    bus.stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      record_consume();
      tick();
    end
    n_chk++; if (got.size() != 6) begin n_err++;
      $display("FAIL pp_count got=%0d want=6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      n_chk++; if (got[k] !== 16'h0200 + 16'(k)) begin n_err++;
        $display("FAIL pp_order[%0d] got=%h want=%h", k, got[k], 16'h0200 + 16'(k)); end
    end
    n_chk++; if (bus.out_word !== '0 || occupancy !== '0) begin n_err++;
      $display("FAIL pp_empty got word=%h occ=%0d want 0/0", bus.out_word, occupancy); end
  endtask

  task automatic test_reset_mid();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h0300 + 16'(i);
      bus.in_addr = 6'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    n_chk++; if (occupancy !== 3'd3 || bus.out_word[BW+NA] !== 1'b1) begin n_err++;
      $display("FAIL rm_pre got occ=%0d v=%b want occ=3 v=1", occupancy, bus.out_word[BW+NA]); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if (bus.out_word !== '0 || occupancy !== '0 || stall_cycles !== '0) begin n_err++;
      $display("FAIL rm_clear got word=%h occ=%0d sc=%0d want 0/0/0",
               bus.out_word, occupancy, stall_cycles); end
    bus.stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (bus.out_word !== '0) begin n_err++;
        $display("FAIL rm_stale[%0d] got=%h want=0", i, bus.out_word); end
    end
  endtask

  task automatic test_saturation();
    bus.stall = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 16'hBEEF;
    bus.in_addr = 6'd63;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    n_chk++; if (stall_cycles !== 16'hFFFF) begin n_err++;
      $display("FAIL sat_max got=%h want=ffff", stall_cycles); end
    n_chk++; if (bus.out_word !== {1'b1, 6'd63, 16'hBEEF}) begin n_err++;
      $display("FAIL sat_hold got=%h want=%h", bus.out_word, {1'b1, 6'd63, 16'hBEEF}); end
    bus.stall = 1'b0;
    tick();
    n_chk++; if (stall_cycles !== 16'd0 || bus.out_word !== '0) begin n_err++;
      $display("FAIL sat_clear got sc=%0d word=%h want 0/0", stall_cycles, bus.out_word); end
  endtask

  task automatic test_random();
    int stall_pct;
    for (int i = 0; i < 600; i++) begin
      stall_pct = ((i / 60) % 3 == 0) ? 10 : (((i / 60) % 3 == 1) ? 50 : 85);
      rst = ($urandom_range(0, 149) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.in_data = 16'($urandom);
      bus.in_addr = 6'($urandom);
      bus.stall = ($urandom_range(0, 99) < stall_pct);
      #1;
      n_chk++; if (bus.in_ready !== exp_ready()) begin n_err++;
        $display("FAIL rnd_ready[%0d] got=%b want=%b", i, bus.in_ready, exp_ready()); end
      tick();
      n_chk++; if (bus.out_word !== exp_word()) begin n_err++;
        $display("FAIL rnd_word[%0d] got=%h want=%h", i, bus.out_word, exp_word()); end
      n_chk++; if (occupancy !== exp_occ()) begin n_err++;
        $display("FAIL rnd_occ[%0d] got=%0d want=%0d", i, occupancy, exp_occ()); end
      n_chk++; if (stall_cycles !== m_sc) begin n_err++;
        $display("FAIL rnd_sc[%0d] got=%0d want=%0d", i, stall_cycles, m_sc); end
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_addr = '0;
    bus.stall = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
